// File: rtl/conv_layer_mem_pkg.sv
// conv_mem_pkg: shared constants and types for the layer-memory responder.
//   DEF_* : default word width, L0/L1 address widths and bank-select width
//   CSEL_L0 / CSEL_L1 : bank-select codes accepted on csel
//   state_t  : handshake FSM encoding (IDLE=0, READY=1, RUN=2, DONE=3)
//   rd_src_t : which source currently drives cdata_rd
package conv_mem_pkg;

    localparam int DEF_DATA_WIDTH = 20;
    localparam int DEF_L0_AW      = 12;
    localparam int DEF_L1_AW      = 10;
    localparam int DEF_SEL_W      = 3;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_L0   = 2'd1,
        RD_L1   = 2'd2
    } rd_src_t;

endpackage

// File: rtl/conv_layer_mem_if.sv
// conv_layer_mem_if: engine <-> layer-memory bundle.
//   master (engine/testbench) drives: start, busy, cwr, caddr_wr, cdata_wr,
//                                     crd, caddr_rd, csel
//   slave  (conv_layer_mem)   drives: ready, cdata_rd, done, err,
//                                     wr_cnt_l0, wr_cnt_l1
interface conv_layer_mem_if
    import conv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int L0_AW      = DEF_L0_AW,
    parameter int L1_AW      = DEF_L1_AW,
    parameter int SEL_W      = DEF_SEL_W
);
    logic                  start;
    logic                  ready;
    logic                  busy;
    logic                  cwr;
    logic [L0_AW-1:0]      caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_wr;
    logic                  crd;
    logic [L0_AW-1:0]      caddr_rd;
    logic [DATA_WIDTH-1:0] cdata_rd;
    logic [SEL_W-1:0]      csel;
    logic                  done;
    logic                  err;
    logic [L0_AW:0]        wr_cnt_l0;
    logic [L1_AW:0]        wr_cnt_l1;

    modport master (
        output start, busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        input  ready, cdata_rd, done, err, wr_cnt_l0, wr_cnt_l1
    );

    modport slave (
        input  start, busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        output ready, cdata_rd, done, err, wr_cnt_l0, wr_cnt_l1
    );
endinterface

// File: rtl/conv_layer_mem_ram.sv
// conv_sp_ram: generic 1-write/1-read synchronous RAM.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port; rdata updates on the edge where re=1 and
//                  holds otherwise
// A same-address read and write on one edge returns the old word.
// The array and rdata have no reset so the array maps onto block RAM.
module conv_sp_ram #(
    parameter int DEPTH_AW = 10,
    parameter int WIDTH    = 20
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DEPTH_AW-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                re,
    input  logic [DEPTH_AW-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);
    logic [WIDTH-1:0] mem [0:(1<<DEPTH_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/conv_layer_mem.sv
// conv_layer_mem: memory-side responder for the convolution engine.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : conv_layer_mem_if.slave (handshake, write/read strobes, status)
// Two banks: L0 (4096 x 20, conv/ReLU) on csel=001 and L1 (1024 x 20,
// max-pool) on csel=010. Accesses are only honoured in RUN; anything else
// (wrong state, bad csel, L1 address beyond 1023) raises the sticky err.
// Optional build macro CONV_LAYER_MEM_WRCNT_EN enables the saturating
// per-bank write counters; without it wr_cnt_l0/wr_cnt_l1 are tied to 0.
module conv_layer_mem
    import conv_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int L0_AW      = DEF_L0_AW,
    parameter int L1_AW      = DEF_L1_AW,
    parameter int SEL_W      = DEF_SEL_W
) (
    input  logic            clk,
    input  logic            reset,
    conv_layer_mem_if.slave bus
);
    state_t  state_reg, state_next;
    rd_src_t rd_src_reg, rd_src_next;
    logic    err_reg, err_next;

    logic    in_run, sel_l0, sel_l1;
    logic    l1_wr_in_range, l1_rd_in_range;
    logic    wr_l0, wr_l1, rd_l0, rd_l1, bad_access;
    logic [DATA_WIDTH-1:0] q0, q1, rd_data;

    // Handshake FSM: next state
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_READY;
            ST_READY: if (bus.busy)  state_next = ST_RUN;
            ST_RUN:   if (!bus.busy) state_next = ST_DONE;
            ST_DONE:  if (bus.start) state_next = ST_READY;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Access decode, read-source tracking and sticky error
    always_comb begin
        in_run         = (state_reg == ST_RUN);
        sel_l0         = (bus.csel == SEL_W'(CSEL_L0));
        sel_l1         = (bus.csel == SEL_W'(CSEL_L1));
        // L1 is addressed with the L0-wide bus; the upper bits must be zero
        l1_wr_in_range = (bus.caddr_wr[L0_AW-1:L1_AW] == '0);
        l1_rd_in_range = (bus.caddr_rd[L0_AW-1:L1_AW] == '0);

        wr_l0 = in_run && bus.cwr && sel_l0;
        wr_l1 = in_run && bus.cwr && sel_l1 && l1_wr_in_range;
        rd_l0 = in_run && bus.crd && sel_l0;
        rd_l1 = in_run && bus.crd && sel_l1 && l1_rd_in_range;

        bad_access = (bus.cwr && !(wr_l0 || wr_l1)) ||
                     (bus.crd && !(rd_l0 || rd_l1));

        // Any read strobe in RUN redirects cdata_rd; a rejected one shows 0.
        // Strobes outside RUN leave cdata_rd untouched.
        rd_src_next = rd_src_reg;
        if (in_run && bus.crd) begin
            rd_src_next = rd_l0 ? RD_L0 : (rd_l1 ? RD_L1 : RD_ZERO);
        end

        // A protocol error on the restart edge still wins over the clear
        err_next = err_reg;
        if (state_reg == ST_DONE && bus.start) begin
            err_next = 1'b0;
        end
        if (bad_access) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            rd_src_reg <= RD_ZERO;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_src_reg <= rd_src_next;
            err_reg    <= err_next;
        end
    end

    conv_sp_ram #(
        .DEPTH_AW (L0_AW),
        .WIDTH    (DATA_WIDTH)
    ) u_ram_l0 (
        .clk   (clk),
        .we    (wr_l0),
        .waddr (bus.caddr_wr),
        .wdata (bus.cdata_wr),
        .re    (rd_l0),
        .raddr (bus.caddr_rd),
        .rdata (q0)
    );

    conv_sp_ram #(
        .DEPTH_AW (L1_AW),
        .WIDTH    (DATA_WIDTH)
    ) u_ram_l1 (
        .clk   (clk),
        .we    (wr_l1),
        .waddr (bus.caddr_wr[L1_AW-1:0]),
        .wdata (bus.cdata_wr),
        .re    (rd_l1),
        .raddr (bus.caddr_rd[L1_AW-1:0]),
        .rdata (q1)
    );

    // The RAM outputs only move on their own read enables, so selecting
    // them with a registered source gives a held, registered cdata_rd
    // that still reads as 0 straight out of reset.
    always_comb begin
        rd_data = '0;
        case (rd_src_reg)
            RD_L0:   rd_data = q0;
            RD_L1:   rd_data = q1;
            default: rd_data = '0;
        endcase
    end

    assign bus.cdata_rd = rd_data;
    assign bus.ready    = (state_reg == ST_READY);
    assign bus.done     = (state_reg == ST_DONE);
    assign bus.err      = err_reg;

`ifdef CONV_LAYER_MEM_WRCNT_EN
    logic           ready_entry;
    logic [L0_AW:0] wr_cnt_l0_reg;
    logic [L1_AW:0] wr_cnt_l1_reg;

    assign ready_entry = (state_next == ST_READY) && (state_reg != ST_READY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_l0_reg <= '0;
            wr_cnt_l1_reg <= '0;
        end else if (ready_entry) begin
            wr_cnt_l0_reg <= '0;
            wr_cnt_l1_reg <= '0;
        end else begin
            if (wr_l0 && !(&wr_cnt_l0_reg)) begin
                wr_cnt_l0_reg <= wr_cnt_l0_reg + 1'b1;
            end
            if (wr_l1 && !(&wr_cnt_l1_reg)) begin
                wr_cnt_l1_reg <= wr_cnt_l1_reg + 1'b1;
            end
        end
    end

    assign bus.wr_cnt_l0 = wr_cnt_l0_reg;
    assign bus.wr_cnt_l1 = wr_cnt_l1_reg;
`else
    assign bus.wr_cnt_l0 = '0;
    assign bus.wr_cnt_l1 = '0;
`endif

endmodule

// File: tb/tb_conv_layer_mem.sv
// tb_conv_layer_mem: directed bench for conv_layer_mem with a behavioural
// reference model and a per-cycle compare process.
module tb_conv_layer_mem;

`ifdef CONV_LAYER_MEM_WRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   checking = 1'b0;

    conv_layer_mem_if bus ();

    conv_layer_mem dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [19:0] ref_l0 [0:4095];
    logic [19:0] ref_l1 [0:1023];
    bit          m_ready, m_run, m_done, m_err;
    logic [19:0] m_rd;
    int          m_c0, m_c1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 0; m_run <= 0; m_done <= 0; m_err <= 0;
            m_rd <= '0; m_c0 <= 0; m_c1 <= 0;
        end else begin
            // a run begins from idle or finished
            if (bus.start && !m_ready && !m_run) begin
                m_ready <= 1; m_done <= 0; m_c0 <= 0; m_c1 <= 0;
                if (m_done) m_err <= 0;
            end
            if (m_ready && bus.busy) begin
                m_ready <= 0; m_run <= 1;
            end
            if (m_run && !bus.busy) begin
                m_run <= 0; m_done <= 1;
            end
            if (bus.cwr) begin
                if (!m_run) m_err <= 1;
                else if (bus.csel == 3'b001) begin
                    ref_l0[bus.caddr_wr] <= bus.cdata_wr;
                    if (m_c0 < 8191) m_c0 <= m_c0 + 1;
                end else if (bus.csel == 3'b010 && bus.caddr_wr < 1024) begin
                    ref_l1[bus.caddr_wr[9:0]] <= bus.cdata_wr;
                    if (m_c1 < 2047) m_c1 <= m_c1 + 1;
                end else m_err <= 1;
            end
            if (bus.crd) begin
                if (!m_run) m_err <= 1;
                else if (bus.csel == 3'b001) m_rd <= ref_l0[bus.caddr_rd];
                else if (bus.csel == 3'b010 && bus.caddr_rd < 1024) m_rd <= ref_l1[bus.caddr_rd[9:0]];
                else begin
                    m_rd <= '0; m_err <= 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_ready", {31'b0, bus.ready}, {31'b0, m_ready});
            check("cyc_done", {31'b0, bus.done}, {31'b0, m_done});
            check("cyc_err", {31'b0, bus.err}, {31'b0, m_err});
            check("cyc_cdata_rd", {12'b0, bus.cdata_rd}, {12'b0, m_rd});
            check("cyc_wr_cnt_l0", {19'b0, bus.wr_cnt_l0}, CNT_EN ? m_c0 : 0);
            check("cyc_wr_cnt_l1", {21'b0, bus.wr_cnt_l1}, CNT_EN ? m_c1 : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d, input bit verbose);
        bus.cwr = 1; bus.csel = sel; bus.caddr_wr = a; bus.cdata_wr = d;
        tick();
        bus.cwr = 0;
        if (verbose) $display("WR   csel=%b addr=%03h data=%05h", sel, a, d);
    endtask

    task automatic do_read(input logic [2:0] sel, input logic [11:0] a);
        bus.crd = 1; bus.csel = sel; bus.caddr_rd = a;
        tick();
        bus.crd = 0;
        @(negedge clk);
        $display("RD   csel=%b addr=%03h data=%05h err=%b", sel, a, bus.cdata_rd, bus.err);
    endtask

    task automatic begin_run();
        bus.start = 1;
        tick();
        bus.start = 0; bus.busy = 1;
        tick();
        $display("RUN  started");
    endtask

    task automatic end_run();
        bus.busy = 0;
        tick();
        $display("RUN  ended, done=%b err=%b", bus.done, bus.err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        bus.start = 0; bus.busy = 0; bus.cwr = 0; bus.crd = 0;
        bus.caddr_wr = '0; bus.cdata_wr = '0; bus.caddr_rd = '0; bus.csel = 3'b001;
        repeat (3) tick();
        @(negedge clk);
        check("reset_ready", {31'b0, bus.ready}, 0);
        check("reset_done", {31'b0, bus.done}, 0);
        check("reset_err", {31'b0, bus.err}, 0);
        check("reset_cdata_rd", {12'b0, bus.cdata_rd}, 0);
        check("reset_cnt_l0", {19'b0, bus.wr_cnt_l0}, 0);
        tick();
        rst_n = 1;
        checking = 1;
        tick();

        // 1: handshake timing
        bus.start = 1;
        tick();
        bus.start = 0;
        $display("HS   start pulse");
        @(negedge clk);
        check("t1_ready_after_start", {31'b0, bus.ready}, 1);
        tick(); tick();
        bus.busy = 1;
        @(negedge clk);
        check("t1_ready_before_busy_edge", {31'b0, bus.ready}, 1);
        tick();
        @(negedge clk);
        check("t1_ready_dropped", {31'b0, bus.ready}, 0);
        repeat (9) tick();
        bus.busy = 0;
        @(negedge clk);
        check("t1_not_done_yet", {31'b0, bus.done}, 0);
        tick();
        @(negedge clk);
        check("t1_done", {31'b0, bus.done}, 1);
        check("t1_err", {31'b0, bus.err}, 0);
        $display("HS   busy fell, done=%b", bus.done);

        // 2: L0 round trip, then a stray read while finished
        begin_run();
        do_write(3'b001, 12'h0A5, 20'h7FFFF, 1);
        do_read(3'b001, 12'h0A5);
        check("t2_l0_readback", {12'b0, bus.cdata_rd}, 32'h7FFFF);
        check("t2_model_pin", {12'b0, m_rd}, 32'h7FFFF);
        tick();
        end_run();
        bus.crd = 1; bus.caddr_rd = 12'h000;
        tick();
        bus.crd = 0;
        @(negedge clk);
        $display("RD   outside RUN, data=%05h err=%b", bus.cdata_rd, bus.err);
        check("t2_read_in_done_err", {31'b0, bus.err}, 1);
        check("t2_read_in_done_hold", {12'b0, bus.cdata_rd}, 32'h7FFFF);

        // 3: L1 bounds
        tick();
        begin_run();
        @(negedge clk);
        check("t3_err_cleared", {31'b0, bus.err}, 0);
        tick();
        do_write(3'b010, 12'd0, 20'h00ABC, 1);
        do_write(3'b010, 12'd1023, 20'h80001, 1);
        do_read(3'b010, 12'd1023);
        check("t3_l1_top_readback", {12'b0, bus.cdata_rd}, 32'h80001);
        tick();
        do_write(3'b010, 12'd1024, 20'h12345, 1);
        @(negedge clk);
        check("t3_l1_oob_err", {31'b0, bus.err}, 1);
        tick();
        do_read(3'b010, 12'd0);
        check("t3_l1_addr0_unchanged", {12'b0, bus.cdata_rd}, 32'h00ABC);
        tick();
        end_run();

        // 4: collision and invalid select
        begin_run();
        do_write(3'b001, 12'd5, 20'h00003, 1);
        bus.cwr = 1; bus.crd = 1; bus.csel = 3'b001;
        bus.caddr_wr = 12'd5; bus.caddr_rd = 12'd5; bus.cdata_wr = 20'h00009;
        tick();
        bus.cwr = 0; bus.crd = 0;
        @(negedge clk);
        $display("RW   addr=005 wdata=00009 rdata=%05h", bus.cdata_rd);
        check("t4_collision_old", {12'b0, bus.cdata_rd}, 32'h00003);
        check("t4_model_pin", {12'b0, m_rd}, 32'h00003);
        check("t4_no_err", {31'b0, bus.err}, 0);
        tick();
        do_read(3'b001, 12'd5);
        check("t4_reread_new", {12'b0, bus.cdata_rd}, 32'h00009);
        tick();
        do_read(3'b100, 12'd5);
        check("t4_bad_sel_zero", {12'b0, bus.cdata_rd}, 0);
        check("t4_bad_sel_err", {31'b0, bus.err}, 1);
        tick();
        end_run();

        // 5: reset in the middle of a run
        begin_run();
        for (int i = 0; i < 50; i++) do_write(3'b001, 12'(100 + i), 20'(i * 37 + 1), 0);
        $display("WR   50 L0 writes at 100..149");
        rst_n = 0; bus.busy = 0;
        #2;
        check("t5_async_ready", {31'b0, bus.ready}, 0);
        check("t5_async_cdata", {12'b0, bus.cdata_rd}, 0);
        check("t5_async_err", {31'b0, bus.err}, 0);
        check("t5_async_cnt_l0", {19'b0, bus.wr_cnt_l0}, 0);
        $display("RST  asserted mid-run");
        tick(); tick();
        rst_n = 1;
        tick();
        begin_run();
        do_read(3'b001, 12'd110);
        check("t5_data_survives", {12'b0, bus.cdata_rd}, 32'h173);
        tick();
        end_run();

        // 6: bulk writes for the counters
        begin_run();
        for (int i = 0; i < 4096; i++) do_write(3'b001, 12'(i), 20'(i * 3), 0);
        for (int i = 0; i < 1024; i++) do_write(3'b010, 12'(i), 20'(i + 7), 0);
        $display("WR   4096 L0 + 1024 L1 writes");
        @(negedge clk);
        check("t6_cnt_l0", {19'b0, bus.wr_cnt_l0}, CNT_EN ? 4096 : 0);
        check("t6_cnt_l1", {21'b0, bus.wr_cnt_l1}, CNT_EN ? 1024 : 0);
        tick();
        do_read(3'b010, 12'd1000);
        check("t6_l1_readback", {12'b0, bus.cdata_rd}, 32'd1007);
        tick();
        end_run();
        begin_run();
        @(negedge clk);
        check("t6_cnt_cleared", {19'b0, bus.wr_cnt_l0}, 0);
        tick();
        end_run();

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
